// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes pwm_in and measures period/high time between rising edges.
// Optional glitch filter on the synchronized level when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module pwm_capture #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period_cycles,
    output logic [CNT_WIDTH-1:0] high_cycles,
    output logic                 meas_valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
        $error("pwm_capture: TIMEOUT_CYCLES must be >= 2 and FILTER_CYCLES >= 1");
    end

    state_t               state, state_nxt;
    logic                 s1, s2, lvl, lvl_d, rise;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] hi, hi_nxt;
    logic [CNT_WIDTH-1:0] idle_cnt, idle_nxt;
    logic [CNT_WIDTH-1:0] period_nxt, high_nxt;
    logic                 valid_nxt, stuck_nxt, level_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            lvl_d <= lvl;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic [FW-1:0] flt_cnt;
    logic          flt_lvl;

    // lvl follows s2 only after FILTER_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt <= '0;
            flt_lvl <= 1'b0;
        end else if (s2 == flt_lvl) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FW'(FILTER_CYCLES - 1)) begin
            flt_lvl <= s2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + FW'(1);
        end
    end

    always_comb lvl = flt_lvl;
`else
    always_comb lvl = s2;
`endif

    always_comb rise = lvl & ~lvl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hi            <= '0;
            idle_cnt      <= '0;
            period_cycles <= '0;
            high_cycles   <= '0;
            meas_valid    <= 1'b0;
            stuck         <= 1'b0;
            stuck_level   <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hi            <= hi_nxt;
            idle_cnt      <= idle_nxt;
            period_cycles <= period_nxt;
            high_cycles   <= high_nxt;
            meas_valid    <= valid_nxt;
            stuck         <= stuck_nxt;
            stuck_level   <= level_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi;
        idle_nxt   = idle_cnt;
        period_nxt = period_cycles;
        high_nxt   = high_cycles;
        valid_nxt  = 1'b0;
        stuck_nxt  = stuck;
        level_nxt  = stuck_level;

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            hi_nxt    = '0;
            idle_nxt  = '0;
            stuck_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    cnt_nxt   = '0;
                    hi_nxt    = '0;
                    idle_nxt  = '0;
                end
                ARM, MEASURE: begin
                    if (rise) begin
                        // a rise always beats a coinciding timeout
                        if (state == MEASURE) begin
                            period_nxt = cnt;
                            high_nxt   = hi;
                            valid_nxt  = 1'b1;
                        end
                        state_nxt = MEASURE;
                        cnt_nxt   = ONE;
                        hi_nxt    = ONE;
                        idle_nxt  = '0;
                        stuck_nxt = 1'b0;
                    end else if (idle_cnt == TO_LAST) begin
                        state_nxt = ARM;
                        cnt_nxt   = '0;
                        hi_nxt    = '0;
                        idle_nxt  = '0;
                        stuck_nxt = 1'b1;
                        level_nxt = lvl;
                    end else begin
                        idle_nxt = idle_cnt + ONE;
                        if (state == MEASURE) begin
                            cnt_nxt = cnt + ONE;
                            hi_nxt  = hi + CNT_WIDTH'(lvl);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected measurements, a monitor pops on meas_valid.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst, enable, pwm_in;
    logic [31:0] period_cycles, high_cycles;
    logic        meas_valid, stuck, stuck_level;

    pwm_capture #(
        .CNT_WIDTH     (32),
        .TIMEOUT_CYCLES(100),
        .FILTER_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .period_cycles(period_cycles),
        .high_cycles  (high_cycles),
        .meas_valid   (meas_valid),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        int gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_strobe_cyc = 0;
    bit   have_prev = 0;
    bit   run_strobe = 0;
    int   prev_p, prev_h;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (meas_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got period=%0d high=%0d, expected no strobe (t=%0t)",
                         period_cycles, high_cycles, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("period", int'(period_cycles), e.p);
                check("high", int'(high_cycles), e.h);
                if (e.gap != 0) check("strobe_gap", cyc - last_strobe_cyc, e.gap);
            end
            last_strobe_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int p, input int h, input int gap);
        exp_t e;
        e.p = p;
        e.h = h;
        e.gap = gap;
        q.push_back(e);
    endtask

    // Rising edge of this pulse completes the previous one.
    task automatic pulse_start(input int p, input int h);
        pwm_in = 1'b1;
        if (have_prev) begin
            push(prev_p, prev_h, run_strobe ? prev_p : 0);
            run_strobe = 1;
        end
        have_prev = 1;
        prev_p = p;
        prev_h = h;
    endtask

    task automatic pulse(input int p, input int h);
        pulse_start(p, h);
        tick(h);
        pwm_in = 1'b0;
        tick(p - h);
    endtask

    task automatic new_run();
        have_prev = 0;
        run_strobe = 0;
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        check("reset_period", int'(period_cycles), 0);
        check("reset_high", int'(high_cycles), 0);
        check("reset_flags", {29'd0, meas_valid, stuck, stuck_level}, 0);
        rst = 1'b0;
        enable = 1'b1;
        tick(3);

        // steady 10/3 then 25/20
        repeat (6) pulse(10, 3);
        check("stuck_idle", int'(stuck), 0);
        repeat (4) pulse(25, 20);

        // hold high: timeout 100 cycles after the last strobe
        pulse_start(0, 0);
        waited = 0;
        while (!stuck && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("stuck_set", int'(stuck), 1);
        check("stuck_delay", cyc - last_strobe_cyc, 100);
        check("stuck_level", int'(stuck_level), 1);
        pwm_in = 1'b0;
        tick(5);
        check("stuck_held", int'(stuck), 1);
        new_run();
        pulse(10, 3);
        check("stuck_cleared", int'(stuck), 0);
        repeat (3) pulse(10, 3);

        // disable for 5 cycles in the low part of a period
        pulse_start(10, 3);
        tick(3);
        pwm_in = 1'b0;
        tick(5);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(1);
        new_run();
        check("hold_period", int'(period_cycles), 10);
        check("hold_high", int'(high_cycles), 3);
        repeat (3) pulse(12, 5);

        // reset mid-measure
        pulse_start(12, 5);
        tick(5);
        pwm_in = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("rst_period", int'(period_cycles), 0);
        check("rst_high", int'(high_cycles), 0);
        check("rst_flags", {29'd0, meas_valid, stuck, stuck_level}, 0);
        rst = 1'b0;
        tick(2);
        new_run();
        repeat (3) pulse(10, 3);

        // 20/10 with a 2-cycle glitch in the low phase
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(2);
        new_run();
        for (int k = 1; k <= 5; k++) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
            if (k > 1) push(20, 10, (k > 2) ? 20 : 0);
`else
            if (k > 1) push(6, 2, 6);
            push(14, 10, (k > 1) ? 14 : 0);
`endif
            pwm_in = 1'b1;
            tick(10);
            pwm_in = 1'b0;
            tick(4);
            pwm_in = 1'b1;
            tick(2);
            pwm_in = 1'b0;
            tick(4);
        end
        tick(20);
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
